// File: rtl/guvm_mem_responder.sv
// Memory-slave responder for a req/gnt/rvalid port: bench-fed read FIFO, write-capture FIFO,
// fixed-latency response pipeline. Define GUVM_MEM_STALL_EN for LFSR-driven grant back-pressure.
module guvm_mem_responder #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int RD_DEPTH = 8,
    parameter int WR_DEPTH = 8,
    parameter int LATENCY  = 1,
    parameter int MAX_OUT  = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_i,
    output logic                         gnt_o,
    input  logic                         we_i,
    input  logic [DATA_W/8-1:0]          be_i,
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    output logic                         rvalid_o,
    output logic [DATA_W-1:0]            rdata_o,
    input  logic                         rd_push_i,
    input  logic [DATA_W-1:0]            rd_push_data_i,
    output logic                         rd_full_o,
    output logic [$clog2(RD_DEPTH+1)-1:0] rd_count_o,
    output logic                         rd_ovf_o,
    output logic                         wr_valid_o,
    input  logic                         wr_pop_i,
    output logic [ADDR_W-1:0]            wr_addr_o,
    output logic [DATA_W-1:0]            wr_data_o,
    output logic [DATA_W/8-1:0]          wr_be_o,
    output logic [$clog2(WR_DEPTH+1)-1:0] wr_count_o
);

    localparam int BE_W = DATA_W / 8;
    localparam int RCW  = $clog2(RD_DEPTH + 1);
    localparam int WCW  = $clog2(WR_DEPTH + 1);
    localparam int RPW  = $clog2(RD_DEPTH);
    localparam int WPW  = $clog2(WR_DEPTH);
    localparam int OCW  = $clog2(MAX_OUT + 1);

    logic [DATA_W-1:0] rd_mem [RD_DEPTH];
    logic [RPW-1:0]    rd_wptr, rd_rptr;
    logic [ADDR_W-1:0] wa_mem [WR_DEPTH];
    logic [DATA_W-1:0] wd_mem [WR_DEPTH];
    logic [BE_W-1:0]   wb_mem [WR_DEPTH];
    logic [WPW-1:0]    wr_wptr, wr_rptr;
    logic [OCW-1:0]    outstanding;

    logic gnt_base, rd_pop, wr_push, rd_push_ok, wr_pop_ok;
    logic              pre_v;
    logic [DATA_W-1:0] pre_d, entry_d;

    always_comb begin
        gnt_base = req_i & ~rst_i & (outstanding < OCW'(MAX_OUT)) &
                   (we_i ? (wr_count_o != WCW'(WR_DEPTH)) : (rd_count_o != '0));
    end

`ifdef GUVM_MEM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign gnt_o = gnt_base & ~lfsr[0];
`else
    assign gnt_o = gnt_base;
`endif

    assign rd_pop     = gnt_o & ~we_i;
    assign wr_push    = gnt_o & we_i;
    assign rd_full_o  = (rd_count_o == RCW'(RD_DEPTH));
    assign rd_push_ok = rd_push_i & ~rd_full_o;
    assign wr_valid_o = (wr_count_o != '0);
    assign wr_pop_ok  = wr_pop_i & wr_valid_o;
    assign entry_d    = rd_pop ? rd_mem[rd_rptr] : '0;

    // Read FIFO: storage has no reset; occupancy alone defines validity.
    always_ff @(posedge clk_i) begin
        if (rd_push_ok) rd_mem[rd_wptr] <= rd_push_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_wptr    <= '0;
            rd_rptr    <= '0;
            rd_count_o <= '0;
            rd_ovf_o   <= 1'b0;
        end else begin
            if (rd_push_ok) rd_wptr <= rd_wptr + 1'b1;
            if (rd_push_i && rd_full_o) rd_ovf_o <= 1'b1;
            if (rd_pop) rd_rptr <= rd_rptr + 1'b1;
            rd_count_o <= rd_count_o + RCW'(rd_push_ok) - RCW'(rd_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_push) begin
            wa_mem[wr_wptr] <= addr_i;
            wd_mem[wr_wptr] <= wdata_i;
            wb_mem[wr_wptr] <= be_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_wptr    <= '0;
            wr_rptr    <= '0;
            wr_count_o <= '0;
        end else begin
            if (wr_push) wr_wptr <= wr_wptr + 1'b1;
            if (wr_pop_ok) wr_rptr <= wr_rptr + 1'b1;
            wr_count_o <= wr_count_o + WCW'(wr_push) - WCW'(wr_pop_ok);
        end
    end

    // Head is forced to zero when empty so the outputs read 0 after reset.
    assign wr_addr_o = wr_valid_o ? wa_mem[wr_rptr] : '0;
    assign wr_data_o = wr_valid_o ? wd_mem[wr_rptr] : '0;
    assign wr_be_o   = wr_valid_o ? wb_mem[wr_rptr] : '0;

    // The rvalid_o/rdata_o register is the last pipeline stage; earlier stages exist only for LATENCY>1.
    generate
        if (LATENCY == 1) begin : g_lat1
            assign pre_v = gnt_o;
            assign pre_d = entry_d;
        end else begin : g_latn
            logic [LATENCY-2:0] pv;
            logic [DATA_W-1:0]  pd [LATENCY-1];

            always_ff @(posedge clk_i) begin
                if (rst_i) pv <= '0;
                else begin
                    pv[0] <= gnt_o;
                    for (int unsigned i = 1; i < unsigned'(LATENCY - 1); i++) pv[i] <= pv[i-1];
                end
            end

            always_ff @(posedge clk_i) begin
                pd[0] <= entry_d;
                for (int unsigned i = 1; i < unsigned'(LATENCY - 1); i++) pd[i] <= pd[i-1];
            end

            assign pre_v = pv[LATENCY-2];
            assign pre_d = pd[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_o    <= 1'b0;
            rdata_o     <= '0;
            outstanding <= '0;
        end else begin
            rvalid_o <= pre_v;
            if (pre_v) rdata_o <= pre_d;
            outstanding <= outstanding + OCW'(gnt_o) - OCW'(rvalid_o);
        end
    end

endmodule
